// File: rtl/ldl_ring_shift_right_pipe.sv
// ---------------------------------------------------------------------------
// ldl_ring_shift_right_pipe
//
// Purpose:
//   Rotates the input word right by a runtime amount. Bits that leave the LSB
//   re-enter at the MSB: y[i] = x[(i + s) mod WIDTH], where s = sel mod WIDTH.
//   The unit is a log2 barrel shifter. It can have a register after every
//   barrel stage, and it always ends in a registered, valid-qualified output.
//
// Parameters:
//   WIDTH     - data width in bits. Must be >= 2; it need not be a power of two.
//   STAGE_REG - 0: a combinational barrel followed by one output register
//                  (latency 1).
//               1: a register after every barrel stage; the last stage
//                  register is the output register (latency SW).
//   SW        - $clog2(WIDTH). This is the width of sel and the number of
//               barrel stages.
//
// Ports:
//   clk       - rising-edge clock
//   rst       - asynchronous active-high reset; clears every register
//   in_valid  - qualifies sel and x in the current cycle
//   sel       - rotate-right amount (reduced mod WIDTH by construction)
//   x         - data word to rotate
//   out_valid - in_valid delayed by the latency
//   y         - rotated result; holds its value while no valid result arrives
// ---------------------------------------------------------------------------
module ldl_ring_shift_right_pipe #(
    parameter  int WIDTH     = 8,
    parameter  int STAGE_REG = 0,
    localparam int SW        = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [SW-1:0]    sel,
    input  logic [WIDTH-1:0] x,
    output logic             out_valid,
    output logic [WIDTH-1:0] y
);

    // Stage k rotates by 2^k mod WIDTH. Because 2^k < WIDTH for every k < SW,
    // the amounts sum to the true (sel mod WIDTH) rotation, even when WIDTH is
    // not a power of two. Each stage passes on only the sel bits that later
    // stages still need, so the sel vector narrows by one bit per stage.
    genvar k;
    generate
        for (k = 0; k < SW; k++) begin : g_stage
            localparam int AMT = (1 << k) % WIDTH;

            logic [WIDTH-1:0] w_din;
            logic [SW-1-k:0]  w_sin;
            logic             w_vin;
            logic [WIDTH-1:0] w_rot;

            if (k == 0) begin : g_src
                assign w_din = x;
                assign w_sin = sel;
                assign w_vin = in_valid;
            end else begin : g_src
                assign w_din = g_stage[k-1].g_next.w_dnext;
                assign w_sin = g_stage[k-1].g_next.w_snext;
                assign w_vin = g_stage[k-1].g_next.w_vnext;
            end

            // AMT is always in 1..WIDTH-1, so both slices are non-empty.
            assign w_rot = w_sin[0] ? {w_din[AMT-1:0], w_din[WIDTH-1:AMT]}
                                    : w_din;

            if (k < SW - 1) begin : g_next
                logic [WIDTH-1:0] w_dnext;
                logic [SW-2-k:0]  w_snext;
                logic             w_vnext;

                if (STAGE_REG != 0) begin : g_reg
                    // ---- stage k register boundary ----
                    logic [WIDTH-1:0] r_d;
                    logic [SW-2-k:0]  r_s;
                    logic             r_v;

                    always_ff @(posedge clk or posedge rst) begin
                        if (rst) begin
                            r_d <= '0;
                            r_s <= '0;
                            r_v <= 1'b0;
                        end else begin
                            r_d <= w_rot;
                            r_s <= w_sin[SW-1-k:1];
                            r_v <= w_vin;
                        end
                    end

                    assign w_dnext = r_d;
                    assign w_snext = r_s;
                    assign w_vnext = r_v;
                end else begin : g_comb
                    assign w_dnext = w_rot;
                    assign w_snext = w_sin[SW-1-k:1];
                    assign w_vnext = w_vin;
                end
            end
        end
    endgenerate

    logic [WIDTH-1:0] w_last_d;
    logic             w_last_v;

    assign w_last_d = g_stage[SW-1].w_rot;
    assign w_last_v = g_stage[SW-1].w_vin;

    // ---- output register boundary ----
    // y loads only on a valid result, so it holds the last result while idle.
    logic [WIDTH-1:0] r_y;
    logic             r_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y   <= '0;
            r_vld <= 1'b0;
        end else begin
            r_vld <= w_last_v;
            if (w_last_v) begin
                r_y <= w_last_d;
            end
        end
    end

    assign y         = r_y;
    assign out_valid = r_vld;

endmodule

// File: tb/tb_ldl_ring_shift_right_pipe.sv
// ---------------------------------------------------------------------------
// Testbench for ldl_ring_shift_right_pipe.
// It instantiates four configurations:
//   a: WIDTH=8, STAGE_REG=0 (latency 1)
//   b: WIDTH=8, STAGE_REG=1 (latency 3)
//   c: WIDTH=6, STAGE_REG=0 (latency 1)
//   d: WIDTH=6, STAGE_REG=1 (latency 3)
// Instances a and b share one stimulus, and c and d share another.
// ---------------------------------------------------------------------------
module tb_ldl_ring_shift_right_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       iv8 = 1'b0;
    logic [2:0] sel8 = '0;
    logic [7:0] x8 = '0;
    logic       iv6 = 1'b0;
    logic [2:0] sel6 = '0;
    logic [5:0] x6 = '0;

    logic       ov_a, ov_b, ov_c, ov_d;
    logic [7:0] y_a, y_b;
    logic [5:0] y_c, y_d;

    int n_vec = 0;
    int n_err = 0;

    ldl_ring_shift_right_pipe #(.WIDTH(8), .STAGE_REG(0)) u_a (
        .clk(clk), .rst(rst), .in_valid(iv8), .sel(sel8), .x(x8),
        .out_valid(ov_a), .y(y_a));
    ldl_ring_shift_right_pipe #(.WIDTH(8), .STAGE_REG(1)) u_b (
        .clk(clk), .rst(rst), .in_valid(iv8), .sel(sel8), .x(x8),
        .out_valid(ov_b), .y(y_b));
    ldl_ring_shift_right_pipe #(.WIDTH(6), .STAGE_REG(0)) u_c (
        .clk(clk), .rst(rst), .in_valid(iv6), .sel(sel6), .x(x6),
        .out_valid(ov_c), .y(y_c));
    ldl_ring_shift_right_pipe #(.WIDTH(6), .STAGE_REG(1)) u_d (
        .clk(clk), .rst(rst), .in_valid(iv6), .sel(sel6), .x(x6),
        .out_valid(ov_d), .y(y_d));

    // Reference rotate, computed with plain integer arithmetic.
    function automatic logic [7:0] rot8(input logic [7:0] v, input logic [2:0] s_raw);
        int s;
        int w;
        s = int'(s_raw) % 8;
        w = int'(v);
        w = (w >> s) | (w << (8 - s));
        return w[7:0];
    endfunction

    function automatic logic [5:0] rot6(input logic [5:0] v, input logic [2:0] s_raw);
        int s;
        int w;
        s = int'(s_raw) % 6;
        w = int'(v);
        w = (w >> s) | (w << (6 - s));
        return w[5:0];
    endfunction

    // Reference model. h*0 and h*1 record the inputs seen at the previous two
    // edges, which the latency-3 instances need.
    logic       h8v0, h8v1, h6v0, h6v1;
    logic [7:0] h8d0, h8d1;
    logic [5:0] h6d0, h6d1;
    logic       m_a_v, m_b_v, m_c_v, m_d_v;
    logic [7:0] m_a_y, m_b_y;
    logic [5:0] m_c_y, m_d_y;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            h8v0 <= 1'b0; h8v1 <= 1'b0; h8d0 <= '0; h8d1 <= '0;
            h6v0 <= 1'b0; h6v1 <= 1'b0; h6d0 <= '0; h6d1 <= '0;
            m_a_v <= 1'b0; m_a_y <= '0; m_b_v <= 1'b0; m_b_y <= '0;
            m_c_v <= 1'b0; m_c_y <= '0; m_d_v <= 1'b0; m_d_y <= '0;
        end else begin
            h8v0 <= iv8; h8d0 <= rot8(x8, sel8); h8v1 <= h8v0; h8d1 <= h8d0;
            h6v0 <= iv6; h6d0 <= rot6(x6, sel6); h6v1 <= h6v0; h6d1 <= h6d0;
            m_a_v <= iv8;
            if (iv8) m_a_y <= rot8(x8, sel8);
            m_b_v <= h8v1;
            if (h8v1) m_b_y <= h8d1;
            m_c_v <= iv6;
            if (iv6) m_c_y <= rot6(x6, sel6);
            m_d_v <= h6v1;
            if (h6v1) m_d_y <= h6d1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tick;
        n_vec++;
        if (y_a !== 8'h00 || ov_a !== 1'b0) begin
            n_err++; $display("FAIL reset_a: got y=%h v=%b, want y=00 v=0", y_a, ov_a);
        end
        n_vec++;
        if (y_b !== 8'h00 || ov_b !== 1'b0) begin
            n_err++; $display("FAIL reset_b: got y=%h v=%b, want y=00 v=0", y_b, ov_b);
        end
        n_vec++;
        if (y_c !== 6'h00 || ov_c !== 1'b0) begin
            n_err++; $display("FAIL reset_c: got y=%h v=%b, want y=00 v=0", y_c, ov_c);
        end
        n_vec++;
        if (y_d !== 6'h00 || ov_d !== 1'b0) begin
            n_err++; $display("FAIL reset_d: got y=%h v=%b, want y=00 v=0", y_d, ov_d);
        end
        rst = 1'b0;
    endtask

    task automatic test_sweep8;
        logic [7:0] tbl [8];
        logic [7:0] ea_y, eb_y;
        logic       ea_v, eb_v;
        tbl = '{8'hA5, 8'hD2, 8'h69, 8'hB4, 8'h5A, 8'h2D, 8'h96, 8'h4B};
        for (int i = 0; i < 11; i++) begin
            iv8  = (i < 8);
            x8   = 8'hA5;
            sel8 = 3'(i);
            tick;
            ea_v = (i < 8);
            ea_y = (i < 8) ? tbl[i] : tbl[7];
            eb_v = (i >= 2 && i < 10);
            eb_y = (i < 2) ? 8'h00 : ((i < 10) ? tbl[i-2] : tbl[7]);
            n_vec++;
            if (y_a !== ea_y || ov_a !== ea_v) begin
                n_err++; $display("FAIL sweep_a[%0d]: got y=%h v=%b, want y=%h v=%b", i, y_a, ov_a, ea_y, ea_v);
            end
            n_vec++;
            if (y_b !== eb_y || ov_b !== eb_v) begin
                n_err++; $display("FAIL sweep_b[%0d]: got y=%h v=%b, want y=%h v=%b", i, y_b, ov_b, eb_y, eb_v);
            end
        end
    endtask

    task automatic test_hold;
        logic [7:0] eb_y;
        logic       eb_v;
        for (int i = 0; i < 4; i++) begin
            iv8  = (i == 0);
            x8   = (i == 0) ? 8'hA5 : 8'hFF;
            sel8 = 3'd3;
            tick;
            n_vec++;
            if (y_a !== 8'hB4 || ov_a !== (i == 0)) begin
                n_err++; $display("FAIL hold_a[%0d]: got y=%h v=%b, want y=b4 v=%b", i, y_a, ov_a, (i == 0));
            end
            eb_y = (i < 2) ? 8'h4B : 8'hB4;
            eb_v = (i == 2);
            n_vec++;
            if (y_b !== eb_y || ov_b !== eb_v) begin
                n_err++; $display("FAIL hold_b[%0d]: got y=%h v=%b, want y=%h v=%b", i, y_b, ov_b, eb_y, eb_v);
            end
        end
        iv8 = 1'b0;
    endtask

    task automatic test_width6;
        logic [2:0] sels [4];
        logic [5:0] exps [4];
        logic [5:0] ec_y, ed_y;
        logic       ec_v, ed_v;
        sels = '{3'd7, 3'd5, 3'd6, 3'd4};
        exps = '{6'b100000, 6'b000010, 6'b000001, 6'b000100};
        for (int i = 0; i < 7; i++) begin
            iv6  = (i < 4);
            x6   = 6'b000001;
            sel6 = (i < 4) ? sels[i] : 3'd0;
            tick;
            ec_v = (i < 4);
            ec_y = (i < 4) ? exps[i] : exps[3];
            ed_v = (i >= 2 && i < 6);
            ed_y = (i < 2) ? 6'd0 : ((i < 6) ? exps[i-2] : exps[3]);
            n_vec++;
            if (y_c !== ec_y || ov_c !== ec_v) begin
                n_err++; $display("FAIL w6_c[%0d]: got y=%b v=%b, want y=%b v=%b", i, y_c, ov_c, ec_y, ec_v);
            end
            n_vec++;
            if (y_d !== ed_y || ov_d !== ed_v) begin
                n_err++; $display("FAIL w6_d[%0d]: got y=%b v=%b, want y=%b v=%b", i, y_d, ov_d, ed_y, ed_v);
            end
        end
        iv6 = 1'b0;
    endtask

    task automatic test_async_reset;
        // Put several valid inputs in flight, then reset between clock edges.
        for (int i = 0; i < 4; i++) begin
            iv8 = 1'b1; x8 = 8'h81 + 8'(i); sel8 = 3'(i + 1);
            iv6 = 1'b1; x6 = 6'h11 + 6'(i); sel6 = 3'(i + 2);
            if (i < 3) tick;
        end
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if (y_a !== 8'h00 || ov_a !== 1'b0 || y_b !== 8'h00 || ov_b !== 1'b0) begin
            n_err++; $display("FAIL async_rst8: got a=%h/%b b=%h/%b, want 00/0", y_a, ov_a, y_b, ov_b);
        end
        n_vec++;
        if (y_c !== 6'h00 || ov_c !== 1'b0 || y_d !== 6'h00 || ov_d !== 1'b0) begin
            n_err++; $display("FAIL async_rst6: got c=%h/%b d=%h/%b, want 00/0", y_c, ov_c, y_d, ov_d);
        end
        tick;
        rst = 1'b0;
        iv8 = 1'b0;
        iv6 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            n_vec++;
            if ({ov_a, ov_b, ov_c, ov_d} !== 4'b0000 || y_a !== 8'h00 || y_b !== 8'h00 ||
                y_c !== 6'h00 || y_d !== 6'h00) begin
                n_err++; $display("FAIL post_rst_quiet[%0d]: got v=%b%b%b%b y=%h %h %h %h, want all 0",
                                  i, ov_a, ov_b, ov_c, ov_d, y_a, y_b, y_c, y_d);
            end
        end
        // A valid input on the first edge after release is accepted.
        iv8 = 1'b1; x8 = 8'h3C; sel8 = 3'd2;
        iv6 = 1'b1; x6 = 6'h21; sel6 = 3'd6;
        tick;
        iv8 = 1'b0;
        iv6 = 1'b0;
        n_vec++;
        if (y_a !== 8'h0F || ov_a !== 1'b1 || y_c !== 6'h21 || ov_c !== 1'b1) begin
            n_err++; $display("FAIL post_rst_first: got a=%h/%b c=%h/%b, want a=0f/1 c=21/1", y_a, ov_a, y_c, ov_c);
        end
        tick;
        tick;
        n_vec++;
        if (y_b !== 8'h0F || ov_b !== 1'b1 || y_d !== 6'h21 || ov_d !== 1'b1) begin
            n_err++; $display("FAIL post_rst_pipe: got b=%h/%b d=%h/%b, want b=0f/1 d=21/1", y_b, ov_b, y_d, ov_d);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 10000; i++) begin
            iv8  = ($urandom_range(0, 3) != 0);
            x8   = 8'($urandom);
            sel8 = 3'($urandom_range(0, 7));
            iv6  = ($urandom_range(0, 3) != 0);
            x6   = 6'($urandom);
            sel6 = 3'($urandom_range(0, 7));
            tick;
            n_vec++;
            if (y_a !== m_a_y || ov_a !== m_a_v) begin
                n_err++; $display("FAIL rand_a[%0d]: got y=%h v=%b, want y=%h v=%b", i, y_a, ov_a, m_a_y, m_a_v);
            end
            n_vec++;
            if (y_b !== m_b_y || ov_b !== m_b_v) begin
                n_err++; $display("FAIL rand_b[%0d]: got y=%h v=%b, want y=%h v=%b", i, y_b, ov_b, m_b_y, m_b_v);
            end
            n_vec++;
            if (y_c !== m_c_y || ov_c !== m_c_v) begin
                n_err++; $display("FAIL rand_c[%0d]: got y=%h v=%b, want y=%h v=%b", i, y_c, ov_c, m_c_y, m_c_v);
            end
            n_vec++;
            if (y_d !== m_d_y || ov_d !== m_d_v) begin
                n_err++; $display("FAIL rand_d[%0d]: got y=%h v=%b, want y=%h v=%b", i, y_d, ov_d, m_d_y, m_d_v);
            end
        end
        iv8 = 1'b0;
        iv6 = 1'b0;
    endtask

    initial begin
        test_reset;
        test_sweep8;
        test_hold;
        test_width6;
        test_async_reset;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
